viterbi_frame_sched: RTL

Frame scheduler for the 7-bit / 14-coded-bit Viterbi decoder datapath.
- Assembles serial coded bits into 14-bit frames held in a two-bank ping-pong buffer.
- Sequences the decoder's add-compare-select (ACS) trellis steps for each frame and collects the decoded word.
- Serializes the 7 decoded bits downstream under a ready/valid handshake.
- Sits between the line receiver and the ACS datapath. Everything runs in the clk1 domain.

---
 rtl/viterbi_frame_sched_if.sv | 37 +++
 rtl/viterbi_frame_sched.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/viterbi_frame_sched_if.sv
// Signal bundle between the line receiver, the ACS datapath, the downstream sink
// and the Viterbi frame scheduler.
interface viterbi_frame_sched_if #(
   parameter int INFO_BITS = 7
);
   localparam int FRAME_BITS = 2 * INFO_BITS;
   localparam int IDX_W      = $clog2(INFO_BITS);

   logic                  in_bit;
   logic                  in_valid;
   logic                  in_sof;
   logic [FRAME_BITS-1:0] frame_out;
   logic                  acs_start;
   logic                  acs_step_valid;
   logic [IDX_W-1:0]      acs_step;
   logic                  acs_done;
   logic [INFO_BITS-1:0]  acs_bits;
   logic                  out_bit;
   logic                  out_valid;
   logic                  out_sof;
   logic                  out_ready;
   logic                  overflow;
   logic                  timeout;
   logic                  busy;

   modport slave (
      input  in_bit, in_valid, in_sof, acs_done, acs_bits, out_ready,
      output frame_out, acs_start, acs_step_valid, acs_step,
             out_bit, out_valid, out_sof, overflow, timeout, busy
   );

   modport master (
      output in_bit, in_valid, in_sof, acs_done, acs_bits, out_ready,
      input  frame_out, acs_start, acs_step_valid, acs_step,
             out_bit, out_valid, out_sof, overflow, timeout, busy
   );
endinterface

// File: rtl/viterbi_frame_sched.sv
// Frame scheduler for the Viterbi decoder: collects coded bits into a ping-pong
// buffer, sequences the ACS trellis steps and serializes the decoded word.
module viterbi_frame_sched #(
   parameter int INFO_BITS  = 7,
   parameter int WAIT_LIMIT = 15
) (
   input logic                   clk1,
   input logic                   reset,
   viterbi_frame_sched_if.slave  bus
);
   localparam int FRAME_BITS = 2 * INFO_BITS;
   localparam int CNT_W      = $clog2(FRAME_BITS);
   localparam int IDX_W      = $clog2(INFO_BITS);
   localparam int WAIT_W     = $clog2(WAIT_LIMIT + 1);

   typedef enum logic [2:0] {IDLE, LOAD, STEP, WAIT, OUT} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [FRAME_BITS-1:0] bank_q [2];
   logic [FRAME_BITS-1:0] bank_d [2];
   logic [1:0]            full_q, full_d;
   logic                  wr_sel_q, wr_sel_d;
   logic                  rd_sel_q, rd_sel_d;
   logic [IDX_W-1:0]      step_q, step_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic [INFO_BITS-1:0]  word_q, word_d;
   logic [IDX_W-1:0]      out_idx_q, out_idx_d;
   logic                  overflow_q, overflow_d;
   logic                  timeout_q, timeout_d;
   logic                  frame_done;
   logic                  release_bank;

   // An sof bit restarts assembly at position 0, discarding any partial frame.
   always_comb begin
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      frame_done = 1'b0;
      if (bus.in_valid) begin
         if (bus.in_sof) begin
            shift_d    = '0;
            shift_d[0] = bus.in_bit;
            cnt_d      = CNT_W'(1);
         end else begin
            shift_d[cnt_q] = bus.in_bit;
            if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
               frame_done = 1'b1;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      step_d       = step_q;
      wait_d       = wait_q;
      word_d       = word_q;
      out_idx_d    = out_idx_q;
      rd_sel_d     = rd_sel_q;
      timeout_d    = timeout_q;
      release_bank = 1'b0;
      case (state_q)
         IDLE: begin
            if (full_q[rd_sel_q]) state_d = LOAD;
         end
         LOAD: begin
            step_d  = '0;
            state_d = STEP;
         end
         STEP: begin
            if (step_q == IDX_W'(INFO_BITS - 1)) begin
               wait_d  = '0;
               state_d = WAIT;
            end else begin
               step_d = step_q + IDX_W'(1);
            end
         end
         WAIT: begin
            if (bus.acs_done) begin
               word_d       = bus.acs_bits;
               out_idx_d    = '0;
               release_bank = 1'b1;
               rd_sel_d     = ~rd_sel_q;
               state_d      = OUT;
            end else if (wait_q == WAIT_W'(WAIT_LIMIT - 1)) begin
               timeout_d    = 1'b1;
               release_bank = 1'b1;
               rd_sel_d     = ~rd_sel_q;
               state_d      = IDLE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         OUT: begin
            // rd_sel already points at the other bank, so a buffered frame loads directly.
            if (bus.out_ready) begin
               word_d = word_q << 1;
               if (out_idx_q == IDX_W'(INFO_BITS - 1)) begin
                  state_d = full_q[rd_sel_q] ? LOAD : IDLE;
               end else begin
                  out_idx_d = out_idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Release is applied before the write so a just-freed bank can take the new frame.
   always_comb begin
      bank_d     = bank_q;
      full_d     = full_q;
      wr_sel_d   = wr_sel_q;
      overflow_d = overflow_q;
      if (release_bank) full_d[rd_sel_q] = 1'b0;
      if (frame_done) begin
         if (!full_d[wr_sel_q]) begin
            bank_d[wr_sel_q] = shift_d;
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk1) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         bank_q[0]  <= '0;
         bank_q[1]  <= '0;
         full_q     <= '0;
         wr_sel_q   <= 1'b0;
         rd_sel_q   <= 1'b0;
         step_q     <= '0;
         wait_q     <= '0;
         word_q     <= '0;
         out_idx_q  <= '0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         bank_q     <= bank_d;
         full_q     <= full_d;
         wr_sel_q   <= wr_sel_d;
         rd_sel_q   <= rd_sel_d;
         step_q     <= step_d;
         wait_q     <= wait_d;
         word_q     <= word_d;
         out_idx_q  <= out_idx_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      bus.frame_out      = (state_q == LOAD || state_q == STEP || state_q == WAIT) ?
                           bank_q[rd_sel_q] : '0;
      bus.acs_start      = (state_q == LOAD);
      bus.acs_step_valid = (state_q == STEP);
      bus.acs_step       = (state_q == STEP) ? step_q : '0;
      bus.out_valid      = (state_q == OUT);
      bus.out_bit        = (state_q == OUT) && word_q[INFO_BITS-1];
      bus.out_sof        = (state_q == OUT) && (out_idx_q == '0);
      bus.overflow       = overflow_q;
      bus.timeout        = timeout_q;
      bus.busy           = (state_q != IDLE);
   end
endmodule
